// File: rtl/qed_mem_pkg.sv
// Shared types and helpers for the SQED dual-half data memory: FSM states, counter saturation, shared word index.
// Combinational-only content; no latency or backpressure of its own.
package qed_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FAIL = 2'd2
  } qed_state_e;

  // Word 0 is visible to both halves, so stores to it never count as original commits.
  localparam int unsigned SHARED_WORD_IDX = 0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/qed_dual_memory_if.sv
// MEM-stage bus between the pipeline (master) and the SQED data memory (slave).
// read_data is 1-cycle registered; no backpressure, the memory accepts every cycle.
interface qed_dual_memory_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
);
  logic              qed_vld_out_ex_mem;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              qed_ready;
  logic              qed_busy;
  logic              qed_pass;
  logic              qed_abort;
  logic              qed_mismatch;
  logic [IDX_W-2:0]  qed_mismatch_idx;

  modport master (
    output qed_vld_out_ex_mem, mem_read, mem_write, address, write_data,
    input  read_data, qed_ready, qed_busy, qed_pass, qed_abort, qed_mismatch, qed_mismatch_idx
  );

  modport slave (
    input  qed_vld_out_ex_mem, mem_read, mem_write, address, write_data,
    output read_data, qed_ready, qed_busy, qed_pass, qed_abort, qed_mismatch, qed_mismatch_idx
  );
endinterface

// File: rtl/qed_pair_scanner.sv
// Walks original/duplicate word pairs one per cycle; H cycles for a clean scan, results registered.
// Any write strobe during a scan cancels it (abort wins over the compare); FAIL holds until reset.
module qed_pair_scanner
  import qed_mem_pkg::*;
#(
  parameter int H      = 16,
  parameter int DATA_W = 32,
  localparam int SW    = $clog2(H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wr_stb,
  input  logic [DATA_W-1:0] orig_word,
  input  logic [DATA_W-1:0] dup_word,
  output logic [SW-1:0]     scan_idx,
  output logic              busy,
  output logic              pass,
  output logic              abort,
  output logic              mismatch,
  output logic [SW-1:0]     mismatch_idx
);

  qed_state_e state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      scan_idx     <= '0;
      busy         <= 1'b0;
      pass         <= 1'b0;
      abort        <= 1'b0;
      mismatch     <= 1'b0;
      mismatch_idx <= '0;
    end else begin
      pass  <= 1'b0;
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SCAN;
            busy     <= 1'b1;
            scan_idx <= '0;
          end
        end
        SCAN: begin
          if (wr_stb) begin
            state <= IDLE;
            busy  <= 1'b0;
            abort <= 1'b1;
          end else if (orig_word != dup_word) begin
            state        <= FAIL;
            busy         <= 1'b0;
            mismatch     <= 1'b1;
            mismatch_idx <= scan_idx;
          end else if (scan_idx == SW'(H - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            pass  <= 1'b1;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end
        FAIL: begin
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/qed_dual_memory.sv
// SQED data memory: split orig/dup array, saturating commit counters, pair scan on balance; read_data 1-cycle latency.
// Never stalls the pipeline; optional properties under `QED_ASSERT_EN.
module qed_dual_memory
  import qed_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input logic              clk,
  input logic              outside_reset,
  qed_dual_memory_if.slave bus
);

  localparam int H  = DEPTH / 2;
  localparam int SW = IDX_W - 1;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] read_q;
  logic [CNT_W-1:0]  orig_cnt;
  logic [CNT_W-1:0]  dup_cnt;
  logic [IDX_W-1:0]  idx;
  logic              wr_commit;
  logic              orig_commit;
  logic              dup_commit;
  logic              ready;
  logic              scan_start;
  logic [SW-1:0]     scan_idx;
  logic              busy_w;
  logic              pass_w;
  logic              abort_w;
  logic              mismatch_w;
  logic [SW-1:0]     mismatch_idx_w;
  logic              unused_addr;

  assign idx         = bus.address[IDX_W+1:2];
  assign unused_addr = ^{bus.address[31:IDX_W+2], bus.address[1:0]};

  // Upper index bit selects the duplicate half.
  assign wr_commit   = bus.qed_vld_out_ex_mem && bus.mem_write;
  assign orig_commit = wr_commit && !idx[IDX_W-1] && (idx != IDX_W'(SHARED_WORD_IDX));
  assign dup_commit  = wr_commit && idx[IDX_W-1];

  always_ff @(posedge clk) begin
    if (bus.mem_write) begin
      mem[idx] <= bus.write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (outside_reset) begin
      read_q   <= '0;
      orig_cnt <= '0;
      dup_cnt  <= '0;
    end else begin
      if (bus.mem_read) begin
        read_q <= mem[idx];
      end
      if (orig_commit) begin
        orig_cnt <= CNT_W'(sat_inc(32'(orig_cnt), CNT_W));
      end
      if (dup_commit) begin
        dup_cnt <= CNT_W'(sat_inc(32'(dup_cnt), CNT_W));
      end
    end
  end

  assign ready      = (orig_cnt == dup_cnt) && (orig_cnt != '0);
  assign scan_start = ready && bus.qed_vld_out_ex_mem && !bus.mem_write;

  qed_pair_scanner #(
    .H      (H),
    .DATA_W (DATA_W)
  ) u_scanner (
    .clk          (clk),
    .rst          (outside_reset),
    .start        (scan_start),
    .wr_stb       (bus.mem_write),
    .orig_word    (mem[{1'b0, scan_idx}]),
    .dup_word     (mem[{1'b1, scan_idx}]),
    .scan_idx     (scan_idx),
    .busy         (busy_w),
    .pass         (pass_w),
    .abort        (abort_w),
    .mismatch     (mismatch_w),
    .mismatch_idx (mismatch_idx_w)
  );

  assign bus.read_data        = read_q;
  assign bus.qed_ready        = ready;
  assign bus.qed_busy         = busy_w;
  assign bus.qed_pass         = pass_w;
  assign bus.qed_abort        = abort_w;
  assign bus.qed_mismatch     = mismatch_w;
  assign bus.qed_mismatch_idx = mismatch_idx_w;

`ifdef QED_ASSERT_EN
  logic pairs_equal;
  logic vld_seen;

  always_comb begin
    pairs_equal = 1'b1;
    for (int i = 0; i < H; i++) begin
      if (mem[i] != mem[i+H]) pairs_equal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (outside_reset) vld_seen <= 1'b0;
    else if (bus.qed_vld_out_ex_mem) vld_seen <= 1'b1;
  end

  // The program under test must start from a symmetric memory image.
  assume property (@(posedge clk) disable iff (outside_reset)
    (bus.qed_vld_out_ex_mem && !vld_seen && orig_cnt == '0 && dup_cnt == '0) |-> pairs_equal);

  assert property (@(posedge clk) disable iff (outside_reset) !$rose(mismatch_w));

  assert property (@(posedge clk) disable iff (outside_reset)
    $onehot0({$rose(pass_w), $rose(abort_w), $rose(mismatch_w)}));
`endif

endmodule

// File: doc/qed_dual_memory.md
# qed_dual_memory

Parametrised SQED data memory for the RISCV-CPU verification build. It holds a word-addressed data array split into an original half and a duplicate half, and counts committed stores into each half. When the two counts balance, it scans every original/duplicate word pair over successive cycles. Pass, mismatch and abort results are reported as registered outputs. It sits in the MEM stage in place of the fixed 32-word, single-pair-check memory, and is driven by the EX/MEM QED valid bit.

## Interface
- DATA_W, 32, data word width
- DEPTH, 32, words in array; power of 2, ≥4; H = DEPTH/2 words per half
- CNT_W, 16, commit counter width
- IDX_W, $clog2(DEPTH), derived word-index width; not overridden
- clk  in  1  single clock, all state on rising edge
- outside_reset  in  1  synchronous, active-high reset
- qed_vld_out_ex_mem  in  1  instruction in MEM is a valid committing QED instruction
- mem_read  in  1  read enable
- mem_write  in  1  write enable
- address  in  32  byte address; word index idx = address[IDX_W+1:2]
- write_data  in  DATA_W  store data
- read_data  out  DATA_W  registered read data
- qed_ready  out  1  orig count == dup count and orig count != 0
- qed_busy  out  1  pair scan in progress
- qed_pass  out  1  one-cycle pulse: full scan found all pairs equal
- qed_abort  out  1  one-cycle pulse: scan cancelled by a write
- qed_mismatch  out  1  sticky: a pair differed
- qed_mismatch_idx  out  IDX_W-1  original index of first failing pair

## Operation
- Array is zero at time 0. Reset does not clear the array.
- Write: if mem_write, mem[idx] <= write_data at the edge.
- Read: if mem_read, read_data <= mem[idx] at the edge; otherwise read_data holds. A read and write to the same idx in one cycle returns the old data.
- Orig commit: qed_vld_out_ex_mem && mem_write && idx < H && idx != 0. Word 0 is shared and never counted.
- Dup commit: qed_vld_out_ex_mem && mem_write && idx >= H.
- Each counter increments by 1 per commit and saturates at 2^CNT_W−1, with no wrap.
- FSM states: IDLE, SCAN, FAIL.
  - IDLE→SCAN when qed_ready && qed_vld_out_ex_mem && !mem_write. scan_idx <= 0.
  - In SCAN, compare mem[scan_idx] with mem[scan_idx+H] each cycle, for scan_idx 0..H−1 (word 0 included).
    - If a write occurs (any idx): →IDLE, pulse qed_abort. Abort takes priority over compare in that cycle.
    - Else if the pair differs: →FAIL, latch qed_mismatch_idx = scan_idx.
    - Else if scan_idx == H−1: →IDLE, pulse qed_pass.
    - Else: scan_idx+1.
  - FAIL is absorbing until reset. Counters keep counting in FAIL.
- Reset values: all outputs 0, counters 0, state IDLE, scan_idx 0.

## Timing
- read_data latency: 1 cycle.
- qed_ready is derived from the registered counters. It is valid the cycle after the balancing commit.
- A clean scan occupies exactly H cycles in SCAN. qed_pass is high in the cycle after the last compare.
- qed_busy = (state == SCAN).
- qed_mismatch and qed_mismatch_idx rise the cycle after the failing compare.
- Reset asserted mid-scan returns to IDLE next cycle, with no pulse.

## Configuration
- QED_ASSERT_EN defined:
  - assume that all H pairs are equal on the first qed_vld_out_ex_mem cycle with both counters 0;
  - assert that qed_mismatch never rises;
  - assert one-hot over qed_pass/qed_abort/qed_mismatch rising.
- QED_ASSERT_EN undefined: no properties; ports and behaviour are identical.

## Structure
- Package qed_mem_pkg holds:
  - the FSM state enum (IDLE, SCAN, FAIL);
  - counter saturation helper function;
  - the word-0-excluded constant.
- Sub-module qed_pair_scanner holds the FSM, scan_idx and result outputs. It takes the two compare words plus the write strobe and is parametrised on H.
- The top holds the array, read register and commit counters.

## Test plan
- Reset with random inputs → all outputs 0; qed_ready 0.
- DEPTH=32: store 0xA5 at 0x04 with vld, then 0xA5 at 0x44 with vld → qed_ready next cycle. A vld, non-write cycle starts the scan → qed_busy for 16 cycles, then a qed_pass pulse, qed_mismatch stays 0.
- Store 0x1 at 0x04 and 0x2 at 0x44 with vld, then trigger → FAIL at scan_idx 1 → qed_mismatch=1, qed_mismatch_idx=1. Both stay high through later traffic until reset.
- Store with vld to 0x00 only → orig count stays 0 and qed_ready stays 0. A later store to 0x40 makes dup=1 and qed_ready stays 0.
- Start a balanced scan, then write at scan cycle 5 → qed_abort pulse, no qed_pass. A re-trigger rescans from index 0.
- Write 0x55 at 0x08; next cycle read 0x08 → read_data=0x55 one cycle later. Simultaneous read of 0x08 with a write of 0x77 → read_data 0x55, then a later read returns 0x77.
